// File: rtl/uart_rx_cfg_if.sv
// Ready/valid holding-register bus between the UART receiver (master) and its consumer (slave).
interface uart_rx_cfg_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] o_RX_Data;
  logic                 o_RX_Valid;
  logic                 i_RX_Ready;
  logic                 o_Parity_Err;
  logic                 o_Frame_Err;

  modport master (
    output o_RX_Data,
    output o_RX_Valid,
    output o_Parity_Err,
    output o_Frame_Err,
    input  i_RX_Ready
  );

  modport slave (
    input  o_RX_Data,
    input  o_RX_Valid,
    input  o_Parity_Err,
    input  o_Frame_Err,
    output i_RX_Ready
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, none/even/odd parity, 1 or 2 stop bits,
// three-sample majority vote per bit and a one-entry ready/valid holding register.
module uart_rx_cfg #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic          i_Clock,
  input  logic          i_Rst,
  input  logic          i_RX_Serial,
  uart_rx_cfg_if.master rx_bus,
  output logic          o_Overrun,
  output logic          o_Busy
);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned H  = (CLKS_PER_BIT - 1) / 2;

  localparam logic [CW-1:0] C_HM1  = CW'(H - 1);
  localparam logic [CW-1:0] C_H    = CW'(H);
  localparam logic [CW-1:0] C_HP1  = CW'(H + 1);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    D_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    S_LAST = 4'(STOP_BITS - 1);
  localparam logic          ODD    = 1'(PARITY == 2);

  typedef enum logic [2:0] {
    S_LINE_WAIT,
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t               state_q;
  logic [1:0]           sync_q;
  logic [CW-1:0]        cnt_q;
  logic [3:0]           idx_q;
  logic                 smp0_q;
  logic                 smp1_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_pend_q;
  logic                 frm_pend_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 perr_q;
  logic                 ferr_q;
  logic                 ovr_q;
  logic                 busy_q;

  logic line_c;
  logic vote_c;
  logic vote_edge_c;
  logic take_c;
  logic exp_par_c;

  assign line_c      = sync_q[1];
  assign vote_c      = (smp0_q & smp1_q) | (smp0_q & line_c) | (smp1_q & line_c);
  assign vote_edge_c = (cnt_q == C_HP1);
  assign take_c      = valid_q & rx_bus.i_RX_Ready;
  assign exp_par_c   = (^shift_q) ^ ODD;

  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      state_q    <= S_LINE_WAIT;
      sync_q     <= 2'b11;
      cnt_q      <= '0;
      idx_q      <= '0;
      smp0_q     <= 1'b1;
      smp1_q     <= 1'b1;
      shift_q    <= '0;
      par_pend_q <= 1'b0;
      frm_pend_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], i_RX_Serial};
      ovr_q  <= 1'b0;
      cnt_q  <= (cnt_q == C_LAST) ? '0 : cnt_q + CW'(1);
      if (take_c) valid_q <= 1'b0;
      // The first two vote samples; the third is the live line at the vote edge.
      if (cnt_q == C_HM1) smp0_q <= line_c;
      if (cnt_q == C_H)   smp1_q <= line_c;

      case (state_q)
        S_LINE_WAIT: begin
          busy_q <= ~line_c;
          if (line_c) state_q <= S_IDLE;
        end
        S_IDLE: begin
          cnt_q <= '0;
          if (!line_c) begin
            state_q    <= S_START;
            busy_q     <= 1'b1;
            par_pend_q <= 1'b0;
            frm_pend_q <= 1'b0;
          end
        end
        S_START: begin
          if (vote_edge_c && vote_c) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == C_LAST) begin
            state_q <= S_DATA;
            idx_q   <= '0;
          end
        end
        S_DATA: begin
          if (vote_edge_c) shift_q <= {vote_c, shift_q[DATA_BITS-1:1]};
          if (cnt_q == C_LAST) begin
            idx_q <= idx_q + 4'd1;
            if (idx_q == D_LAST) begin
              state_q <= (PARITY != 0) ? S_PAR : S_STOP;
              idx_q   <= '0;
            end
          end
        end
        S_PAR: begin
          if (vote_edge_c) par_pend_q <= vote_c ^ exp_par_c;
          if (cnt_q == C_LAST) begin
            state_q <= S_STOP;
            idx_q   <= '0;
          end
        end
        S_STOP: begin
          if (vote_edge_c) begin
            if (!vote_c) frm_pend_q <= 1'b1;
            // Final stop bit completes the frame at its centre so back-to-back starts are caught.
            if (idx_q == S_LAST) begin
              state_q <= vote_c ? S_IDLE : S_LINE_WAIT;
              busy_q  <= ~vote_c;
              if (!valid_q || take_c) begin
                data_q  <= shift_q;
                perr_q  <= par_pend_q;
                ferr_q  <= frm_pend_q | ~vote_c;
                valid_q <= 1'b1;
              end else begin
                ovr_q <= 1'b1;
              end
            end
          end else if (cnt_q == C_LAST) begin
            idx_q <= idx_q + 4'd1;
          end
        end
        default: begin
          state_q <= S_LINE_WAIT;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign rx_bus.o_RX_Data    = data_q;
  assign rx_bus.o_RX_Valid   = valid_q;
  assign rx_bus.o_Parity_Err = perr_q;
  assign rx_bus.o_Frame_Err  = ferr_q;
  assign o_Overrun           = ovr_q;
  assign o_Busy              = busy_q;
endmodule
